// File: rtl/spi_byte_sequencer.sv
// Byte-stream front end for an SPI master byte engine: TX/RX FIFOs, one
// outstanding transaction at a time, and a programmable idle gap between transfers.
module spi_byte_sequencer #(
  parameter  int DEPTH = 8,
  parameter  int GAP   = 2,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic          m_start,
  output logic [7:0]    m_tx_data,
  input  logic [7:0]    m_rx_data,
  input  logic          m_done,
  output logic [LW-1:0] tx_level,
  output logic [LW-1:0] rx_level,
  output logic          busy,
  output logic          proto_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [7:0]      txd_q, txd_d;
  logic            perr_q, perr_d;
  logic            abort_q, abort_d;
  logic            init_q;

  logic [7:0]      tx_mem [DEPTH];
  logic [7:0]      rx_mem [DEPTH];
  logic [AW-1:0]   tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [LW-1:0]   tx_lvl_q, rx_lvl_q;

  logic            tx_wr, rx_push, rx_pop, launch;

  assign in_ready  = init_q && (tx_lvl_q != LW'(DEPTH));
  assign tx_wr     = in_valid && in_ready;
  assign out_valid = (rx_lvl_q != '0);
  assign out_data  = out_valid ? rx_mem[rx_rp_q] : 8'h00;
  assign rx_pop    = out_valid && out_ready;
  assign rx_push   = (state_q == S_WAIT) && m_done;

  assign m_start   = (state_q == S_START);
  assign m_tx_data = txd_q;
  assign busy      = (state_q != S_IDLE);
  assign proto_err = perr_q;
  assign tx_level  = tx_lvl_q;
  assign rx_level  = rx_lvl_q;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    txd_d   = txd_q;
    perr_d  = perr_q;
    abort_d = abort_q;
    launch  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // RX room is reserved at launch; only one transfer is ever outstanding
        if (tx_lvl_q != '0 && rx_lvl_q != LW'(DEPTH)) begin
          launch  = 1'b1;
          txd_d   = tx_mem[tx_rp_q];
          state_d = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (m_done) begin
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // A done belonging to a transfer killed by reset is swallowed once
    if (m_done && state_q != S_WAIT) begin
      if (abort_q) abort_d = 1'b0;
      else         perr_d  = 1'b1;
    end
    if (launch) abort_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gap_q    <= '0;
      txd_q    <= '0;
      perr_q   <= 1'b0;
      init_q   <= 1'b0;
      abort_q  <= (state_q == S_START) || (state_q == S_WAIT) || (abort_q && !init_q);
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_lvl_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_lvl_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      txd_q   <= txd_d;
      perr_q  <= perr_d;
      abort_q <= abort_d;
      init_q  <= 1'b1;
      if (tx_wr)   tx_wp_q <= tx_wp_q + AW'(1);
      if (launch)  tx_rp_q <= tx_rp_q + AW'(1);
      if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
      case ({tx_wr, launch})
        2'b10:   tx_lvl_q <= tx_lvl_q + LW'(1);
        2'b01:   tx_lvl_q <= tx_lvl_q - LW'(1);
        default: tx_lvl_q <= tx_lvl_q;
      endcase
      case ({rx_push, rx_pop})
        2'b10:   rx_lvl_q <= rx_lvl_q + LW'(1);
        2'b01:   rx_lvl_q <= rx_lvl_q - LW'(1);
        default: rx_lvl_q <= rx_lvl_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && tx_wr)   tx_mem[tx_wp_q] <= in_data;
    if (!rst && rx_push) rx_mem[rx_wp_q] <= m_rx_data;
  end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Directed bench for spi_byte_sequencer: cycle-stepped host/master model with
// level and data scoreboards, plus a GAP=0 instance for launch spacing.
module tb_spi_byte_sequencer;
  localparam int DEPTH = 8;
  localparam int GAP   = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          in_valid = 1'b0, out_ready = 1'b0, m_done = 1'b0;
  logic [7:0]    in_data = 8'h00, m_rx_data = 8'h00;
  logic          in_ready, out_valid, m_start, busy, proto_err;
  logic [7:0]    out_data, m_tx_data;
  logic [LW-1:0] tx_level, rx_level;

  logic          z_in_valid = 1'b0, z_out_ready = 1'b0, z_m_done = 1'b0;
  logic [7:0]    z_in_data = 8'h00, z_m_rx_data = 8'h00;
  logic          z_in_ready, z_out_valid, z_m_start, z_busy, z_proto_err;
  logic [7:0]    z_out_data, z_m_tx_data;
  logic [LW-1:0] z_tx_level, z_rx_level;

  spi_byte_sequencer #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .m_start(m_start), .m_tx_data(m_tx_data), .m_rx_data(m_rx_data), .m_done(m_done),
    .tx_level(tx_level), .rx_level(rx_level), .busy(busy), .proto_err(proto_err)
  );

  spi_byte_sequencer #(.DEPTH(DEPTH), .GAP(0)) dz (
    .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_data(z_in_data), .in_ready(z_in_ready),
    .out_valid(z_out_valid), .out_data(z_out_data), .out_ready(z_out_ready),
    .m_start(z_m_start), .m_tx_data(z_m_tx_data), .m_rx_data(z_m_rx_data), .m_done(z_m_done),
    .tx_level(z_tx_level), .rx_level(z_rx_level), .busy(z_busy), .proto_err(z_proto_err)
  );

  int n_assert = 0, n_fail = 0, cyc = 0;
  int tx_cnt, rx_cnt, mcnt, lat, pv, pr, n_start, done_edge, wr_first, st_first;
  bit have_done, exact_gap, wr_pend, rd_pend, done_pend, rx_fix_en;
  logic [7:0] held, wr_byte, rx_fix;
  logic [7:0] src_q[$], sent_q[$], exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    tx_cnt = 0; rx_cnt = 0; mcnt = 0; n_start = 0; done_edge = 0;
    wr_first = -1; st_first = -1;
    have_done = 0; exact_gap = 0; wr_pend = 0; rd_pend = 0; done_pend = 0; rx_fix_en = 0;
    held = 8'h00; src_q.delete(); sent_q.delete(); exp_q.delete();
  endtask

  task automatic chk_reset_vals();
    chk("rst_m_start",   32'(m_start),   0);
    chk("rst_m_tx_data", 32'(m_tx_data), 0);
    chk("rst_busy",      32'(busy),      0);
    chk("rst_proto_err", 32'(proto_err), 0);
    chk("rst_tx_level",  32'(tx_level),  0);
    chk("rst_rx_level",  32'(rx_level),  0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data),  0);
    chk("rst_in_ready",  32'(in_ready),  0);
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; out_ready = 0; m_done = 0;
    z_in_valid = 0; z_out_ready = 0; z_m_done = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 0;
    @(posedge clk); #1;
    chk("in_ready_post_rst", 32'(in_ready), 1);
    model_reset();
  endtask

  // One clock: account for the previous edge, check, then drive the next edge
  task automatic step();
    logic [7:0] e;
    @(posedge clk); #1;
    cyc++;
    if (wr_pend)   begin tx_cnt++; sent_q.push_back(wr_byte); end
    if (rd_pend)   rx_cnt--;
    if (done_pend) rx_cnt++;
    if (m_start)   tx_cnt--;
    chk("tx_level", 32'(tx_level), tx_cnt);
    chk("rx_level", 32'(rx_level), rx_cnt);

    m_done = 1'b0; done_pend = 0;
    if (m_start) begin
      chk("busy_start", 32'(busy), 1);
      chk("start_has_data", 32'(sent_q.size() != 0), 1);
      if (sent_q.size() != 0) begin
        e = sent_q.pop_front();
        chk("m_tx_data", 32'(m_tx_data), 32'(e));
      end
      held = m_tx_data; n_start++;
      if (st_first < 0) st_first = cyc;
      if (have_done) begin
        if (exact_gap) chk("gap_exact", cyc - done_edge, GAP + 1);
        else           chk("gap_min", 32'(cyc - done_edge >= GAP + 1), 1);
      end
      mcnt = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
    end else if (mcnt > 0) begin
      chk("m_tx_hold", 32'(m_tx_data), 32'(held));
      chk("busy_wait", 32'(busy), 1);
      mcnt--;
      if (mcnt == 0) begin
        e = rx_fix_en ? rx_fix : ~held;
        m_done = 1'b1; m_rx_data = e; exp_q.push_back(e);
        done_pend = 1; done_edge = cyc + 1; have_done = 1;
      end
    end

    rd_pend = 0;
    chk("out_valid", 32'(out_valid), 32'(rx_cnt != 0));
    out_ready = ($urandom_range(0, 99) < pr);
    if (out_ready && out_valid) begin
      chk("rx_has_exp", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e));
      end
      rd_pend = 1;
    end

    wr_pend = 0;
    chk("in_ready", 32'(in_ready), 32'(tx_cnt != DEPTH));
    in_valid = 1'b0;
    if (src_q.size() != 0 && $urandom_range(0, 99) < pv) begin
      in_valid = 1'b1; in_data = src_q[0];
      if (in_ready) begin
        wr_pend = 1; wr_byte = src_q.pop_front();
        if (wr_first < 0) wr_first = cyc + 1;
      end
    end
  endtask

  task automatic run_until_drained(input int n_exp, input int max_cyc);
    int k = 0;
    while (!(n_start == n_exp && exp_q.size() == 0 && mcnt == 0 && src_q.size() == 0)
           && k < max_cyc) begin
      step();
      k++;
    end
    chk("drain_in_time", 32'(k < max_cyc), 1);
    chk("n_start", n_start, n_exp);
  endtask

  initial begin
    int k;
    logic [7:0] b;

    // Reset values and single-byte loopback
    do_reset();
    src_q.push_back(8'hA5); rx_fix_en = 1; rx_fix = 8'h3C;
    lat = 16; pv = 100; pr = 100;
    run_until_drained(1, 200);
    chk("wr_to_start", st_first - wr_first, 1);

    // Burst of DEPTH bytes, master returns the complement
    do_reset();
    for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
    lat = 3; pv = 100; pr = 100; exact_gap = 1;
    run_until_drained(8, 400);

    // RX backpressure: RX fills, TX keeps the remainder
    do_reset();
    for (int i = 0; i < 10; i++) src_q.push_back(8'(8'h10 + i));
    lat = 2; pv = 100; pr = 0;
    repeat (120) step();
    chk("bp_n_start",  n_start, 8);
    chk("bp_tx_level", 32'(tx_level), 2);
    chk("bp_rx_level", 32'(rx_level), 8);
    chk("bp_busy",     32'(busy), 0);
    pr = 100; step(); pr = 0;
    repeat (40) step();
    chk("bp_one_more",   n_start, 9);
    chk("bp_rx_full",    32'(rx_level), 8);
    chk("bp_tx_left",    32'(tx_level), 1);
    pr = 100;
    run_until_drained(10, 500);

    // Wrap and same-cycle push/pop with random handshakes
    do_reset();
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom_range(0, 255));
      src_q.push_back(b);
    end
    lat = 0; pv = 60; pr = 60;
    run_until_drained(40, 4000);
    chk("wrap_perr_clean", 32'(proto_err), 0);

    // Stray done in IDLE is sticky and pushes nothing
    do_reset();
    m_done = 1; m_rx_data = 8'h77;
    @(posedge clk); #1; m_done = 0;
    chk("stray_perr",   32'(proto_err), 1);
    chk("stray_rx_lvl", 32'(rx_level), 0);
    chk("stray_oval",   32'(out_valid), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("stray_sticky", 32'(proto_err), 1);

    // Reset during WAIT, then a late done is ignored
    do_reset();
    in_valid = 1; in_data = 8'h5A;
    @(posedge clk); #1; in_valid = 0;
    k = 0;
    while (!m_start && k < 20) begin @(posedge clk); #1; k++; end
    chk("mw_start_seen", 32'(k < 20), 1);
    chk("mw_tx_data", 32'(m_tx_data), 32'h5A);
    @(posedge clk); #1;
    chk("mw_busy", 32'(busy), 1);
    rst = 1;
    @(posedge clk); #1;
    chk_reset_vals();
    rst = 0;
    @(posedge clk); #1;
    chk("mw_in_ready", 32'(in_ready), 1);
    m_done = 1; m_rx_data = 8'h99;
    @(posedge clk); #1; m_done = 0;
    chk("late_done_perr", 32'(proto_err), 0);
    chk("late_done_rx",   32'(rx_level), 0);
    chk("late_done_busy", 32'(busy), 0);
    m_done = 1;
    @(posedge clk); #1; m_done = 0;
    chk("next_stray_perr", 32'(proto_err), 1);

    // GAP=0 build: relaunch one edge after done
    do_reset();
    z_in_valid = 1; z_in_data = 8'h11;
    @(posedge clk); #1; z_in_data = 8'h22;
    @(posedge clk); #1; z_in_valid = 0;
    k = 0;
    while (!z_m_start && k < 20) begin @(posedge clk); #1; k++; end
    chk("z_start_seen", 32'(k < 20), 1);
    chk("z_tx_first",   32'(z_m_tx_data), 32'h11);
    @(posedge clk); #1;
    z_m_done = 1; z_m_rx_data = 8'hC3;
    @(posedge clk); #1; z_m_done = 0;
    chk("z_no_start_yet", 32'(z_m_start), 0);
    chk("z_busy_idle",    32'(z_busy), 0);
    chk("z_out_valid",    32'(z_out_valid), 1);
    chk("z_out_data",     32'(z_out_data), 32'hC3);
    @(posedge clk); #1;
    chk("z_second_start", 32'(z_m_start), 1);
    chk("z_tx_second",    32'(z_m_tx_data), 32'h22);
    chk("z_perr",         32'(z_proto_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
